// File: rtl/clock_12h_pkg.sv
// Shared types and constants for the 12-hour clock time transmitter.
package clock_12h_pkg;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

    localparam logic [2:0] FRAME_MARKER   = 3'b101;
    localparam int         HOUR_MAX       = 12;
    localparam int         MIN_MAX        = 59;
    localparam int         BITS_PER_FRAME = 20;

    function automatic logic time_valid(input logic [3:0] h, input logic [5:0] m);
        return (h != 4'd0) && (h <= 4'(HOUR_MAX)) && (m <= 6'(MIN_MAX));
    endfunction

endpackage

// File: rtl/clock_12h_baud_gen.sv
// Bit-period counter; bit_tick marks the last cycle of each serial bit.
module clock_12h_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic bit_tick
);

    localparam int             CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap   = (r_cnt == LAST);
    assign bit_tick = w_wrap && !clear;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (clear || w_wrap)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/clock_12h_time_tx.sv
// Sends every change of the 12-hour time as a two-byte 8N1 frame; snapshot
// at launch, latest value wins, invalid times are reported once on err.
module clock_12h_time_tx
    import clock_12h_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] hour,
    input  logic [5:0] minute,
    input  logic       pm,
    input  logic       send_req,
    output logic       tx,
    output logic       busy,
    output logic       frame_done,
    output logic       err
);

    state_e      r_state, w_next;
    logic [10:0] w_cur;
    logic [10:0] r_last;
    logic [10:0] r_bad;
    logic        r_bad_vld;
    logic        r_pend;
    logic [15:0] r_shift;
    logic [2:0]  r_bit;
    logic        r_byte;
    logic        r_tx, r_done, r_err;
    logic        w_tick, w_valid, w_trig, w_idle, w_launch, w_reject;

    assign w_cur   = {pm, hour, minute};
    assign w_valid = time_valid(hour, minute);
    assign w_idle  = (r_state == IDLE);
    // A rejected value stays quiet until the inputs move or a resend is asked for.
    assign w_trig   = ((w_cur != r_last) && !(r_bad_vld && (w_cur == r_bad)))
                      || send_req || r_pend;
    assign w_launch = w_idle && w_trig && w_valid;
    assign w_reject = w_idle && w_trig && !w_valid;

    clock_12h_baud_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (w_launch),
        .bit_tick (w_tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_launch) w_next = START;
            START:   if (w_tick) w_next = DATA;
            DATA:    if (w_tick && (r_bit == 3'd7)) w_next = STOP;
            STOP:    if (w_tick) w_next = r_byte ? IDLE : START;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx    <= 1'b1;
            r_shift <= '0;
            r_bit   <= '0;
            r_byte  <= 1'b0;
            r_last  <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_err  <= w_reject;
            if (w_launch) begin
                // byte1 sits above byte0 so one right shift walks both bytes.
                r_shift <= {2'b00, minute, FRAME_MARKER, pm, hour};
                r_last  <= w_cur;
                r_tx    <= 1'b0;
                r_bit   <= '0;
                r_byte  <= 1'b0;
            end else if (w_tick) begin
                case (r_state)
                    START: r_tx <= r_shift[0];
                    DATA: begin
                        r_shift <= {1'b0, r_shift[15:1]};
                        r_bit   <= r_bit + 3'd1;
                        r_tx    <= (r_bit == 3'd7) ? 1'b1 : r_shift[1];
                    end
                    STOP: begin
                        if (!r_byte) begin
                            r_byte <= 1'b1;
                            r_tx   <= 1'b0;
                        end else begin
                            r_done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend    <= 1'b0;
            r_bad     <= '0;
            r_bad_vld <= 1'b0;
        end else begin
            if (w_launch || w_reject)
                r_pend <= 1'b0;
            else if (send_req)
                r_pend <= 1'b1;

            if (w_reject) begin
                r_bad     <= w_cur;
                r_bad_vld <= 1'b1;
            end else if (w_cur != r_bad) begin
                r_bad_vld <= 1'b0;
            end
        end
    end

    assign tx         = r_tx;
    assign busy       = (r_state != IDLE);
    assign frame_done = r_done;
    assign err        = r_err;

endmodule

// File: tb/tb_clock_12h_time_tx.sv
// Directed bench for clock_12h_time_tx with CLKS_PER_BIT=4.
module tb_clock_12h_time_tx;

    localparam int CPB = 4;
    localparam int FB  = 20 * CPB;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] hour = 4'd12;
    logic [5:0] minute = 6'd0;
    logic       pm = 1'b0;
    logic       send_req = 1'b0;
    logic       tx, busy, frame_done, err;

    int checks = 0;
    int failures = 0;
    int mid_mode = 0;

    logic [7:0] b0, b1;
    int         waited;
    logic       shape_ok, done_ok;
    int         lows, busies, dones, errs;

    always #5 clk = ~clk;

    clock_12h_time_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .hour       (hour),
        .minute     (minute),
        .pm         (pm),
        .send_req   (send_req),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    // Input activity injected at fixed sample indices of an in-flight frame.
    task automatic do_mid(input int i);
        if (mid_mode == 1 && i == 20) begin hour = 4'd12; minute = 6'd0; pm = 1'b0; end
        if (mid_mode == 1 && i == 40) minute = 6'd1;
        if (mid_mode == 2 && i == 20) send_req = 1'b1;
        if (mid_mode == 2 && i == 21) send_req = 1'b0;
    endtask

    task automatic recv_frame(output logic [7:0] r0, output logic [7:0] r1, output int wt,
                              output logic sh_ok, output logic dn_ok);
        logic [FB-1:0] s;
        wt = -1; r0 = '0; r1 = '0; sh_ok = 1'b0; dn_ok = 1'b0; s = '0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin wt = k; break; end
        end
        if (wt < 0) return;
        sh_ok = 1'b1; dn_ok = 1'b1;
        for (int i = 0; i < FB; i++) begin
            if (i > 0) @(negedge clk);
            s[i] = tx;
            if (busy !== 1'b1) sh_ok = 1'b0;
            if (frame_done !== 1'b0) dn_ok = 1'b0;
            do_mid(i);
        end
        @(negedge clk);
        if (frame_done !== 1'b1 || busy !== 1'b0) dn_ok = 1'b0;
        for (int j = 0; j < 20; j++)
            for (int c = 1; c < CPB; c++)
                if (s[j*CPB+c] !== s[j*CPB]) sh_ok = 1'b0;
        if (s[0] !== 1'b0 || s[10*CPB] !== 1'b0 || s[9*CPB] !== 1'b1 || s[19*CPB] !== 1'b1)
            sh_ok = 1'b0;
        for (int d = 0; d < 8; d++) begin
            r0[d] = s[(1+d)*CPB];
            r1[d] = s[(11+d)*CPB];
        end
    endtask

    task automatic idle_watch(input int n, output int lo, output int bs, output int dn, output int er);
        lo = 0; bs = 0; dn = 0; er = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lo++;
            if (busy !== 1'b0) bs++;
            if (frame_done !== 1'b0) dn++;
            if (err !== 1'b0) er++;
        end
    endtask

    task automatic pulse_req();
        @(posedge clk); #1 send_req = 1'b1;
        @(posedge clk); #1 send_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; hour = 4'd12; minute = 6'd0; pm = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if ({tx, busy, frame_done, err} !== 4'b1000) begin failures++;
            $display("FAIL reset_outputs got=%b exp=1000", {tx, busy, frame_done, err}); end
        @(posedge clk); #1 rst_n = 1'b1;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 1) begin failures++; $display("FAIL reset_latency got=%0d exp=1", waited); end
        checks++; if (b0 !== 8'hAC) begin failures++; $display("FAIL reset_byte0 got=%h exp=ac", b0); end
        checks++; if (b1 !== 8'h00) begin failures++; $display("FAIL reset_byte1 got=%h exp=00", b1); end
        checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL reset_shape got=%b exp=1", shape_ok); end
        checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL reset_done got=%b exp=1", done_ok); end
        idle_watch(40, lows, busies, dones, errs);
        checks++; if (lows + busies + dones + errs !== 0) begin failures++;
            $display("FAIL reset_no_more got=%0d/%0d/%0d/%0d exp=0/0/0/0", lows, busies, dones, errs); end
    endtask

    task automatic test_basic();
        @(posedge clk); #1 hour = 4'd11; minute = 6'd59; pm = 1'b1;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 1) begin failures++; $display("FAIL basic_latency got=%0d exp=1", waited); end
        checks++; if (b0 !== 8'hBB) begin failures++; $display("FAIL basic_byte0 got=%h exp=bb", b0); end
        checks++; if (b1 !== 8'h3B) begin failures++; $display("FAIL basic_byte1 got=%h exp=3b", b1); end
        checks++; if (shape_ok !== 1'b1) begin failures++; $display("FAIL basic_bit_width got=%b exp=1", shape_ok); end
        checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL basic_done got=%b exp=1", done_ok); end
    endtask

    task automatic test_send_req_idle();
        pulse_req();
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 0) begin failures++; $display("FAIL req_latency got=%0d exp=0", waited); end
        checks++; if ({b0, b1} !== 16'hBB3B) begin failures++; $display("FAIL req_bytes got=%h exp=bb3b", {b0, b1}); end
        idle_watch(30, lows, busies, dones, errs);
        checks++; if (lows + busies !== 0) begin failures++; $display("FAIL req_single got=%0d exp=0", lows + busies); end
    endtask

    task automatic test_midframe();
        pulse_req();
        mid_mode = 1;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        mid_mode = 0;
        checks++; if ({b0, b1} !== 16'hBB3B) begin failures++; $display("FAIL mid_snapshot got=%h exp=bb3b", {b0, b1}); end
        checks++; if (done_ok !== 1'b1) begin failures++; $display("FAIL mid_done got=%b exp=1", done_ok); end
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 0) begin failures++; $display("FAIL mid_follow_latency got=%0d exp=0", waited); end
        checks++; if ({b0, b1} !== 16'hAC01) begin failures++; $display("FAIL mid_follow_bytes got=%h exp=ac01", {b0, b1}); end
        idle_watch(30, lows, busies, dones, errs);
        checks++; if (lows + busies !== 0) begin failures++; $display("FAIL mid_collapse got=%0d exp=0", lows + busies); end
    endtask

    task automatic test_invalid();
        @(posedge clk); #1 hour = 4'd13; minute = 6'd5; pm = 1'b0;
        idle_watch(30, lows, busies, dones, errs);
        checks++; if (errs !== 1) begin failures++; $display("FAIL invalid_err_count got=%0d exp=1", errs); end
        checks++; if (lows + busies !== 0) begin failures++; $display("FAIL invalid_no_frame got=%0d exp=0", lows + busies); end
        @(posedge clk); #1 hour = 4'd1;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 1) begin failures++; $display("FAIL recover_latency got=%0d exp=1", waited); end
        checks++; if ({b0, b1} !== 16'hA105) begin failures++; $display("FAIL recover_bytes got=%h exp=a105", {b0, b1}); end
    endtask

    task automatic test_back_to_back();
        pulse_req();
        mid_mode = 2;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        mid_mode = 0;
        checks++; if ({b0, b1} !== 16'hA105) begin failures++; $display("FAIL b2b_first got=%h exp=a105", {b0, b1}); end
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 0) begin failures++; $display("FAIL b2b_latency got=%0d exp=0", waited); end
        checks++; if ({b0, b1} !== 16'hA105) begin failures++; $display("FAIL b2b_second got=%h exp=a105", {b0, b1}); end
        idle_watch(30, lows, busies, dones, errs);
        checks++; if (lows + busies !== 0) begin failures++; $display("FAIL b2b_only_one got=%0d exp=0", lows + busies); end
    endtask

    task automatic test_reset_midframe();
        int seen;
        seen = 0;
        pulse_req();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (tx === 1'b0) begin seen = 1; break; end
        end
        checks++; if (seen !== 1) begin failures++; $display("FAIL rstmid_start got=%0d exp=1", seen); end
        repeat (33) @(negedge clk);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rstmid_inflight got=%b exp=1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if ({tx, busy} !== 2'b10) begin failures++; $display("FAIL rstmid_async got=%b exp=10", {tx, busy}); end
        repeat (2) @(negedge clk);
        checks++; if ({tx, busy, frame_done} !== 3'b100) begin failures++;
            $display("FAIL rstmid_hold got=%b exp=100", {tx, busy, frame_done}); end
        @(posedge clk); #1 rst_n = 1'b1;
        recv_frame(b0, b1, waited, shape_ok, done_ok);
        checks++; if (waited !== 1) begin failures++; $display("FAIL rstmid_latency got=%0d exp=1", waited); end
        checks++; if ({b0, b1} !== 16'hA105) begin failures++; $display("FAIL rstmid_resend got=%h exp=a105", {b0, b1}); end
        checks++; if ({shape_ok, done_ok} !== 2'b11) begin failures++; $display("FAIL rstmid_frame got=%b exp=11", {shape_ok, done_ok}); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_send_req_idle();
        test_midframe();
        test_invalid();
        test_back_to_back();
        test_reset_midframe();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
